// File: rtl/ascii_num_parser_pkg.sv
// rtl/ascii_num_parser_pkg.sv - ASCII constants, parser state and byte classes for ascii_num_parser
package aoc_parse_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [1:0] {IDLE, NUM, EMIT} parse_state_t;

  typedef enum logic [2:0] {CLS_DIGIT, CLS_NL, CLS_CR, CLS_MINUS, CLS_SEP} byte_class_t;

  function automatic byte_class_t classify(input logic [7:0] b, input logic signed_en);
    byte_class_t c;
    if (b >= CH_0 && b <= CH_9)        c = CLS_DIGIT;
    else if (b == CH_NL)               c = CLS_NL;
    else if (b == CH_CR)               c = CLS_CR;
    else if (signed_en && b == CH_MINUS) c = CLS_MINUS;
    else                               c = CLS_SEP;
    return c;
  endfunction

  // True when the largest DIGITS-digit decimal number fits in w bits.
  function automatic logic fits_width(input int digits, input int w);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < digits; i++) p = p * 128'd10;
    return (w >= 127) || (((p - 128'd1) >> w) == 128'd0);
  endfunction

endpackage

// File: rtl/ascii_num_parser_if.sv
// rtl/ascii_num_parser_if.sv - byte input stream and record output stream of ascii_num_parser
interface ascii_num_parser_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;
  logic         out_eol;
  logic         out_empty;
  logic         out_ovf;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_eol, out_empty, out_ovf, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_value, out_eol, out_empty, out_ovf, out_last
  );
endinterface

// File: rtl/ascii_num_parser_bcd2bin.sv
// rtl/ascii_num_parser_bcd2bin.sv - bcd2bin: combinational packed-BCD to binary converter
module bcd2bin #(
  parameter  int W  = 32,
  localparam int BW = W + (W - 4) / 3 + 1
) (
  input  logic [BW-1:0] bcd,
  output logic [W-1:0]  bin
);
  localparam int ND = (BW + 3) / 4;

  logic [4*ND-1:0] bcd_pad;
  logic [W-1:0]    acc;

  assign bcd_pad = (4*ND)'(bcd);

  // Horner evaluation, most significant digit first: acc = acc*10 + digit.
  always_comb begin
    acc = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      acc = (acc << 3) + (acc << 1) + W'(bcd_pad[4*i +: 4]);
    end
    bin = acc;
  end
endmodule

// File: rtl/ascii_num_parser.sv
// rtl/ascii_num_parser.sv - ASCII byte stream to binary number records with blank-line/end markers
// Define SIGNED_NUM_EN to accept '-' prefixed numbers (two's complement output).
module ascii_num_parser
  import aoc_parse_pkg::*;
#(
  parameter int W      = 32,
  parameter int DIGITS = 9
) (
  input logic              clock,
  input logic              reset_n,
  ascii_num_parser_if.slave bus
);
  localparam int BW   = W + (W - 4) / 3 + 1;
  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = $clog2(DIGITS + 1);

`ifdef SIGNED_NUM_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  if (BCDW > BW || !fits_width(DIGITS, W)) begin : g_bad_cfg
    $error("ascii_num_parser: DIGITS=%0d does not fit W=%0d", DIGITS, W);
  end

  parse_state_t    state_q, state_d;
  logic [BCDW-1:0] bcd_q, bcd_d, bcd_shift;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            prev_nl_q, prev_nl_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    value_q, value_d;
  logic            eol_q, eol_d;
  logic            empty_q, empty_d;
  logic            rovf_q, rovf_d;
  logic            last_q, last_d;

  logic [W-1:0]    bin, signed_val;
  byte_class_t     cls;
  logic            accept, digit_fits;
  logic            rec_num, rec_empty, rec_eol;

  assign cls        = classify(bus.in_data, SIGNED_EN);
  assign bus.in_ready = (state_q != EMIT);
  assign accept     = bus.in_valid && bus.in_ready;
  assign digit_fits = (cnt_q < CW'(DIGITS));
  // Conversion sees the register plus the byte being accepted, so a digit carrying in_last counts.
  assign bcd_shift  = (cls == CLS_DIGIT && digit_fits) ? BCDW'({bcd_q, bus.in_data[3:0]}) : bcd_q;
  assign signed_val = neg_q ? -bin : bin;

  bcd2bin #(.W(W)) u_bcd2bin (
    .bcd (BW'(bcd_shift)),
    .bin (bin)
  );

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    prev_nl_d = prev_nl_q;
    neg_d     = neg_q;
    value_d   = value_q;
    eol_d     = eol_q;
    empty_d   = empty_q;
    rovf_d    = rovf_q;
    last_d    = last_q;
    rec_num   = 1'b0;
    rec_empty = 1'b0;
    rec_eol   = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        case (cls)
          CLS_DIGIT: begin
            bcd_d   = bcd_shift;
            cnt_d   = CW'(1);
            state_d = NUM;
            rec_num = bus.in_last;
          end
          CLS_NL: begin
            neg_d = 1'b0;
            if (prev_nl_q) begin
              rec_empty = 1'b1;
              rec_eol   = 1'b1;
            end else begin
              prev_nl_d = 1'b1;
            end
          end
          CLS_CR: ;
          CLS_MINUS: begin
            neg_d     = 1'b1;
            prev_nl_d = 1'b0;
          end
          default: begin
            neg_d     = 1'b0;
            prev_nl_d = 1'b0;
          end
        endcase
        if (bus.in_last && cls != CLS_DIGIT && !(cls == CLS_NL && prev_nl_q)) rec_empty = 1'b1;
      end
      NUM: if (accept) begin
        case (cls)
          CLS_DIGIT: begin
            bcd_d = bcd_shift;
            if (digit_fits) cnt_d = cnt_q + CW'(1);
            else            ovf_d = 1'b1;
            rec_num = bus.in_last;
          end
          CLS_CR: rec_num = bus.in_last;
          default: begin
            rec_num   = 1'b1;
            rec_eol   = (cls == CLS_NL);
            prev_nl_d = (cls == CLS_NL);
          end
        endcase
      end
      EMIT: if (bus.out_ready) begin
        state_d = IDLE;
        bcd_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        neg_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (rec_num || rec_empty) begin
      state_d = EMIT;
      value_d = rec_num ? signed_val : '0;
      eol_d   = rec_eol;
      empty_d = !rec_num;
      rovf_d  = rec_num && ovf_d;
      last_d  = bus.in_last;
      // A fresh input after the end starts as if at the beginning of a line.
      if (bus.in_last) prev_nl_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      prev_nl_q <= 1'b1;
      neg_q     <= 1'b0;
      value_q   <= '0;
      eol_q     <= 1'b0;
      empty_q   <= 1'b0;
      rovf_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      prev_nl_q <= prev_nl_d;
      neg_q     <= neg_d;
      value_q   <= value_d;
      eol_q     <= eol_d;
      empty_q   <= empty_d;
      rovf_q    <= rovf_d;
      last_q    <= last_d;
    end
  end

  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_value = value_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_empty = empty_q;
  assign bus.out_ovf   = rovf_q;
  assign bus.out_last  = last_q;

endmodule

// File: doc/ascii_num_parser.md
Name: ascii_num_parser

Overview:
Byte-stream front end that sits directly upstream of the accumulator / adder-tree stages used by each puzzle. It consumes ASCII puzzle input one byte per cycle and packs decimal digits into a BCD shift register. On each delimiter it converts the number to binary through an instance of the shared bcd2bin module and emits one record per number over a valid/ready handshake. It also emits explicit blank-line and end-of-input markers, so downstream FSMs can split input into records.

Parameters:
W, 32, binary output width; passed to bcd2bin.
DIGITS, 9, maximum decimal digits per number. Elaboration error unless 4*DIGITS <= W+(W-4)/3+1 and 10^DIGITS-1 < 2^W.

Ports:
clock  in  1  single clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid
in_ready  out  1  parser accepts a byte this cycle
in_data  in  8  ASCII byte
in_last  in  1  final byte of input; qualified by in_valid
out_valid  out  1  record valid
out_ready  in  1  downstream accepts record
out_value  out  W  parsed number, binary
out_eol  out  1  number was terminated by '\n'
out_empty  out  1  marker record with no number (blank line or bare end); out_value=0
out_ovf  out  1  number had more than DIGITS digits; value holds first DIGITS digits
out_last  out  1  last record of the input

Behaviour:
- Reset (async assert, sync deassert assumed from top): state=IDLE; BCD reg, digit count, ovf, prev_nl(=1) cleared; out_valid=0, out_value=0, all out flags 0; in_ready=1 after reset release.
- Handshake: byte accepted when in_valid&&in_ready. Record consumed when out_valid&&out_ready. out_* stay stable while out_valid&&!out_ready.
- in_ready = (state != EMIT). One bubble cycle per record; no combinational out_ready->in_ready path.
- Byte classes: digit '0'..'9'; newline 0x0A; CR 0x0D is ignored entirely and does not change prev_nl; every other byte is a separator.
- IDLE (no pending digits):
  - digit: bcd <= {bcd,d}, cnt=1, go to NUM.
  - newline with prev_nl=1: emit empty record (out_empty=1, out_eol=1) and go to EMIT.
  - newline with prev_nl=0: set prev_nl only.
  - separator: ignored; prev_nl <= 0.
- NUM:
  - digit with cnt<DIGITS: shift in, cnt++.
  - digit with cnt==DIGITS: digit dropped, ovf <= 1.
  - newline or separator: latch the record, out_eol = (byte==newline), prev_nl <= (byte==newline), go to EMIT.
- in_last: processed as above, then treated as a terminator.
  - Digit with in_last: the number includes that digit and is emitted with out_eol=0.
  - In IDLE, a non-digit with in_last emits an empty record, except when that byte already produces a blank-line record; in that case the flag rides on that record.
  - out_last=1 on the resulting record.
- EMIT: out_valid=1. The record is registered the cycle after the terminating byte is accepted: latency 1, and bcd2bin sits in front of that register. On consume: clear bcd/cnt/ovf, go to IDLE, out_valid deasserts next cycle.
- Back-to-back delimiters (e.g. "12, 7"): the second delimiter falls in IDLE and is ignored, so there are no duplicate records.
- Reset asserted mid-number or mid-EMIT: the pending record is discarded and out_valid drops immediately.

Optional Feature:
SIGNED_NUM_EN: when defined, '-' in IDLE arms neg, and a following digit enters NUM with neg set. On emit, out_value = -bin (two's complement W bits). '-' followed by a non-digit disarms neg and emits nothing. Without the macro, '-' is a plain separator and out_value is unsigned.

Decomposition:
- Package aoc_parse_pkg holds:
  - ASCII constants: CH_0, CH_9, CH_NL, CH_CR, CH_MINUS.
  - enum typedef parse_state_t {IDLE, NUM, EMIT}.
  - typedef for the byte class.
- The only sub-module is the existing bcd2bin, instantiated with W. No other sub-module is needed.

Test Plan:
- "123,45\n" with out_ready=1 -> records 123 (eol=0), 45 (eol=1); each out_valid appears exactly 1 cycle after its delimiter is accepted.
- "7\n\n8" with in_last on '8' -> 7 (eol=1), empty record (empty=1, eol=1), 8 (last=1, eol=0).
- "1234567890 " with DIGITS=9 -> value 123456789, ovf=1; the next number has ovf=0.
- "5  ,\r\n9\n" with out_ready held low for 4 cycles on the first record -> in_ready=0 throughout, record 5 stable and not duplicated; separators produce no extra records; 9 follows.
- Reset_n pulsed low while parsing "98" before a delimiter -> out_valid=0 at once; after release, "3\n" yields 3, not 983.
- SIGNED_NUM_EN: "-42 -x 3" -> 0xFFFFFFD6, then 3; the "-x" pair emits nothing.
